// File: rtl/msu_job_driver.sv
// msu_job_driver: serialises one MSU job onto AXI-stream, collects the framed reply and presents it.
// Optional watchdog enabled by defining MSU_DRV_TIMEOUT_EN.
module msu_job_driver #(
  parameter int AXI_LEN = 32,
  parameter int T_LEN = 64,
  parameter int SQ_IN_BITS = 1024,
  parameter int SQ_OUT_BITS = 1056,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [T_LEN-1:0]       job_t_start,
  input  logic [T_LEN-1:0]       job_t_final,
  input  logic [SQ_IN_BITS-1:0]  job_sq_in,
  output logic                   ap_start,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [AXI_LEN-1:0]     m_axis_tdata,
  output logic [AXI_LEN/8-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [AXI_LEN-1:0]     s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [T_LEN-1:0]       res_t_current,
  output logic [SQ_OUT_BITS-1:0] res_sq_out,
  output logic                   res_deadlock,
  output logic                   res_frame_err,
  output logic                   res_timeout,
  output logic                   busy
);
  localparam int IN_COUNT = (2*T_LEN + SQ_IN_BITS + AXI_LEN - 1) / AXI_LEN;
  localparam int OUT_COUNT = (T_LEN + SQ_OUT_BITS + AXI_LEN - 1) / AXI_LEN;
  localparam int IN_W = IN_COUNT * AXI_LEN;
  localparam int OUT_W = OUT_COUNT * AXI_LEN;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] RECV = 3'd3;
  localparam logic [2:0] DELIVER = 3'd4;

  logic [2:0] state;
  logic [IN_W-1:0] tx_sr;
  logic [OUT_W-1:0] rx_sr, rx_nxt;
  logic [15:0] tx_cnt, rx_cnt;
  logic [31:0] rx_sh;
  logic frame_err, timeout, tx_hs, rx_hs, rx_end, rx_done, wd_fire;

  assign tx_hs = m_axis_tvalid && m_axis_tready;
  assign rx_hs = s_axis_tvalid && s_axis_tready;
  assign rx_nxt = {s_axis_tdata, rx_sr[OUT_W-1:AXI_LEN]};
  assign rx_end = rx_cnt == 16'(OUT_COUNT - 1);
  assign rx_done = rx_hs && (s_axis_tlast || rx_end);
  // An early tlast leaves the words in the top of the register; this drops the stale words below them.
  assign rx_sh = 32'((OUT_COUNT - 1 - int'(rx_cnt)) * AXI_LEN);

`ifdef MSU_DRV_TIMEOUT_EN
  logic [31:0] wd;
  assign wd_fire = (state == SEND || state == RECV) && !tx_hs && !rx_hs && wd == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset || !(state == SEND || state == RECV) || tx_hs || rx_hs) wd <= '0;
    else wd <= wd + 32'd1;
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx_sr <= '0;
      rx_sr <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      frame_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_err <= 1'b0;
          timeout <= 1'b0;
          if (job_valid) begin
            tx_sr <= IN_W'({job_sq_in, job_t_final, job_t_start});
            rx_sr <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            state <= START;
          end
        end
        START: state <= SEND;
        SEND: begin
          if (tx_hs) begin
            tx_sr <= tx_sr >> AXI_LEN;
            tx_cnt <= tx_cnt + 16'd1;
            if (m_axis_tlast) state <= RECV;
          end
          if (wd_fire) begin
            timeout <= 1'b1;
            state <= DELIVER;
          end
        end
        RECV: begin
          if (rx_hs) begin
            rx_sr <= rx_done ? rx_nxt >> rx_sh : rx_nxt;
            rx_cnt <= rx_cnt + 16'd1;
          end
          if (rx_done) begin
            frame_err <= s_axis_tlast != rx_end;
            state <= DELIVER;
          end
          if (wd_fire) begin
            timeout <= 1'b1;
            state <= DELIVER;
          end
        end
        DELIVER:
          if (res_ready) begin
            frame_err <= 1'b0;
            timeout <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end

  assign job_ready = state == IDLE;
  assign ap_start = state == START;
  assign m_axis_tvalid = state == SEND;
  assign m_axis_tdata = tx_sr[AXI_LEN-1:0];
  assign m_axis_tkeep = '1;
  assign m_axis_tlast = m_axis_tvalid && tx_cnt == 16'(IN_COUNT - 1);
  assign s_axis_tready = state == RECV;
  assign res_valid = state == DELIVER;
  assign res_t_current = rx_sr[T_LEN-1:0];
  assign res_sq_out = rx_sr[T_LEN +: SQ_OUT_BITS];
  assign res_deadlock = res_valid && &res_t_current;
  assign res_frame_err = frame_err;
  assign res_timeout = timeout;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_msu_job_driver.sv
// tb_msu_job_driver: random jobs against a queue/array model of the MSU job driver, plus literal anchors.
module tb_msu_job_driver;
  localparam int AXI_LEN = 32, T_LEN = 64, SQ_IN_BITS = 1024, SQ_OUT_BITS = 1056, TO = 100;
  localparam int IN_COUNT = (2*T_LEN + SQ_IN_BITS + AXI_LEN - 1) / AXI_LEN;
  localparam int OUT_COUNT = (T_LEN + SQ_OUT_BITS + AXI_LEN - 1) / AXI_LEN;
  localparam int IN_W = IN_COUNT * AXI_LEN;
  localparam int OUT_W = OUT_COUNT * AXI_LEN;

  logic clk = 0, reset = 1;
  logic job_valid = 0, job_ready;
  logic [T_LEN-1:0] job_t_start = '0, job_t_final = '0;
  logic [SQ_IN_BITS-1:0] job_sq_in = '0;
  logic ap_start, m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
  logic [AXI_LEN-1:0] m_axis_tdata;
  logic [AXI_LEN/8-1:0] m_axis_tkeep;
  logic s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic [AXI_LEN-1:0] s_axis_tdata = '0;
  logic res_valid, res_ready = 0, res_deadlock, res_frame_err, res_timeout, busy;
  logic [T_LEN-1:0] res_t_current;
  logic [SQ_OUT_BITS-1:0] res_sq_out;

  int n_tests = 0, n_fail = 0;
  logic exp_on = 0, exp_de = 0, exp_fe = 0, exp_to = 0;
  logic [T_LEN-1:0] exp_t = '0;
  logic [SQ_OUT_BITS-1:0] exp_sq = '0;
  logic [IN_W-1:0] pk;
  logic [AXI_LEN-1:0] txw [IN_COUNT];
  logic [AXI_LEN-1:0] rw [OUT_COUNT];
  int tlast_at;

  msu_job_driver #(.AXI_LEN(AXI_LEN), .T_LEN(T_LEN), .SQ_IN_BITS(SQ_IN_BITS),
                   .SQ_OUT_BITS(SQ_OUT_BITS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_t_start(job_t_start), .job_t_final(job_t_final), .job_sq_in(job_sq_in),
    .ap_start(ap_start), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .res_valid(res_valid), .res_ready(res_ready),
    .res_t_current(res_t_current), .res_sq_out(res_sq_out), .res_deadlock(res_deadlock),
    .res_frame_err(res_frame_err), .res_timeout(res_timeout), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic chkw(input string nm, input logic [SQ_OUT_BITS-1:0] a, input logic [SQ_OUT_BITS-1:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      for (int i = 0; i < SQ_OUT_BITS/AXI_LEN; i++)
        if (a[i*AXI_LEN +: AXI_LEN] !== e[i*AXI_LEN +: AXI_LEN]) begin
          $display("FAIL %s: word %0d got %h expected %h", nm, i, a[i*AXI_LEN +: AXI_LEN], e[i*AXI_LEN +: AXI_LEN]);
          break;
        end
    end
  endtask

  // Result compare process: every cycle a result is presented it must match the model.
  always @(negedge clk)
    if (exp_on && res_valid) begin
      chk("res_t_current", res_t_current, exp_t);
      chkw("res_sq_out", res_sq_out, exp_sq);
      chk("res_deadlock", res_deadlock, exp_de);
      chk("res_frame_err", res_frame_err, exp_fe);
      chk("res_timeout", res_timeout, exp_to);
    end

  task automatic rand_job();
    job_t_start = {$urandom, $urandom};
    job_t_final = {$urandom, $urandom};
    for (int k = 0; k < SQ_IN_BITS/32; k++) job_sq_in[k*32 +: 32] = $urandom;
  endtask

  task automatic rand_reply();
    for (int k = 0; k < OUT_COUNT; k++) rw[k] = $urandom;
    tlast_at = OUT_COUNT - 1;
  endtask

  task automatic give_job();
    int c = 0;
    while (!job_ready && c < 50) begin @(negedge clk); c++; end
    chk("job_ready_idle", job_ready, 1);
    pk = IN_W'({job_sq_in, job_t_final, job_t_start});
    job_valid = 1;
    @(negedge clk);
    job_valid = 0;
    chk("ap_start_pulse", ap_start, 1);
    chk("no_tvalid_in_start", m_axis_tvalid, 0);
    @(negedge clk);
    chk("tvalid_latency2", m_axis_tvalid, 1);
  endtask

  // mode 0: always ready, 1: ready pattern 1-0-0-1, 2: random
  task automatic send_phase(input int mode, input int abort_after, output int got);
    int cyc = 0, aps = 0;
    logic stalled = 0;
    logic [AXI_LEN-1:0] pd = '0;
    logic pl = 0;
    got = 0;
    while (got < IN_COUNT && cyc < 2000) begin
      m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      s_axis_tvalid = 1;
      s_axis_tdata = $urandom;
      s_axis_tlast = 1;
      if (ap_start) aps++;
      chk("s_tready_outside_recv", s_axis_tready, 0);
      chk("m_tvalid_send", m_axis_tvalid, 1);
      if (stalled) begin
        chk("tdata_hold", m_axis_tdata, pd);
        chk("tlast_hold", m_axis_tlast, pl);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        txw[got] = m_axis_tdata;
        chk($sformatf("tx_word%0d", got), m_axis_tdata, pk[got*AXI_LEN +: AXI_LEN]);
        chk($sformatf("tx_tlast%0d", got), m_axis_tlast, got == IN_COUNT - 1);
        got++;
      end
      stalled = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      cyc++;
      @(negedge clk);
      if (got == abort_after) break;
    end
    m_axis_tready = 0;
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    chk("ap_start_once", aps, 0);
    if (abort_after < 0) chk("tx_word_count", got, IN_COUNT);
  endtask

  task automatic recv_phase(input int gap);
    int i = 0, cyc = 0;
    int n = tlast_at >= 0 ? tlast_at + 1 : OUT_COUNT;
    logic [OUT_W-1:0] r = '0;
    for (int k = 0; k < n; k++) r[k*AXI_LEN +: AXI_LEN] = rw[k];
    exp_t = r[T_LEN-1:0];
    exp_sq = r[T_LEN +: SQ_OUT_BITS];
    exp_de = &exp_t;
    exp_fe = tlast_at != OUT_COUNT - 1;
    exp_to = 0;
    exp_on = 1;
    while (i < n && cyc < 2000) begin
      s_axis_tvalid = gap != 0 ? $urandom_range(0, 3) != 0 : 1'b1;
      s_axis_tdata = rw[i];
      s_axis_tlast = i == tlast_at;
      chk("s_tready_recv", s_axis_tready, 1);
      chk("no_res_before_done", res_valid, 0);
      if (s_axis_tvalid && s_axis_tready) i++;
      cyc++;
      @(negedge clk);
    end
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    chk("rx_word_count", i, n);
    chk("res_valid_after_rx", res_valid, 1);
  endtask

  task automatic deliver(input int hold);
    for (int h = 0; h < hold; h++) begin
      res_ready = 0;
      chk("res_valid_held", res_valid, 1);
      @(negedge clk);
    end
    res_ready = 1;
    chk("res_valid_at_hs", res_valid, 1);
    @(negedge clk);
    res_ready = 0;
    exp_on = 0;
    chk("res_valid_drop", res_valid, 0);
    chk("job_ready_after_hs", job_ready, 1);
    chk("busy_idle", busy, 0);
    chk("frame_err_clear", res_frame_err, 0);
  endtask

  initial begin
    int got;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_t_current", res_t_current, 0);
    chk("rst_tkeep", m_axis_tkeep, 4'hF);

    // basic job with hand-computed expectations
    job_t_start = 0; job_t_final = 5; job_sq_in = 3;
    for (int k = 0; k < OUT_COUNT; k++) rw[k] = 0;
    rw[0] = 5; rw[2] = 9; tlast_at = OUT_COUNT - 1;
    give_job();
    send_phase(0, -1, got);
    chk("basic_word0", txw[0], 0);
    chk("basic_word1", txw[1], 0);
    chk("basic_word2", txw[2], 5);
    chk("basic_word4", txw[4], 3);
    chk("basic_word35", txw[35], 0);
    recv_phase(0);
    chk("basic_t_current", res_t_current, 5);
    chk("basic_sq_lo", res_sq_out[31:0], 32'h9);
    chk("basic_frame_err", res_frame_err, 0);
    chk("basic_deadlock", res_deadlock, 0);
    deliver(0);

    // backpressure
    rand_job(); rand_reply();
    give_job();
    send_phase(1, -1, got);
    recv_phase(1);
    deliver(10);

    // deadlock marker
    rand_job(); rand_reply();
    rw[0] = 32'hFFFFFFFF; rw[1] = 32'hFFFFFFFF;
    give_job();
    send_phase(0, -1, got);
    recv_phase(0);
    chk("deadlock_flag", res_deadlock, 1);
    deliver(1);

    // early tlast on word 20
    rand_job(); rand_reply(); tlast_at = 20;
    give_job();
    send_phase(2, -1, got);
    recv_phase(0);
    chk("early_frame_err", res_frame_err, 1);
    chk("early_aligned_last", res_sq_out[18*32 +: 32], rw[20]);
    chk("early_aligned_above", res_sq_out[19*32 +: 32], 0);
    deliver(2);

    // missing tlast
    rand_job(); rand_reply(); tlast_at = -1;
    give_job();
    send_phase(0, -1, got);
    recv_phase(1);
    chk("missing_tlast_err", res_frame_err, 1);
    deliver(0);

    // reset mid-send after 10 words
    rand_job();
    give_job();
    send_phase(0, 10, got);
    reset = 1;
    @(negedge clk);
    chk("abort_tvalid", m_axis_tvalid, 0);
    chk("abort_job_ready", job_ready, 1);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_tlast", m_axis_tlast, 0);
    reset = 0;
    rand_job(); rand_reply();
    give_job();
    send_phase(0, -1, got);
    recv_phase(0);
    deliver(0);

    // random jobs
    for (int j = 0; j < 4; j++) begin
      int r;
      rand_job(); rand_reply();
      r = $urandom_range(0, 3);
      tlast_at = r == 0 ? -1 : r == 1 ? int'($urandom_range(0, OUT_COUNT - 2)) : OUT_COUNT - 1;
      give_job();
      send_phase(2, -1, got);
      recv_phase(1);
      deliver($urandom_range(0, 3));
    end

`ifdef MSU_DRV_TIMEOUT_EN
    begin
      int c = 0;
      rand_job();
      give_job();
      send_phase(0, -1, got);
      exp_t = '0; exp_sq = '0; exp_de = 0; exp_fe = 0; exp_to = 1; exp_on = 1;
      while (!res_valid && c < 300) begin @(negedge clk); c++; end
      chk("timeout_latency", c, TO);
      chk("timeout_flag", res_timeout, 1);
      chk("timeout_s_tready", s_axis_tready, 0);
      deliver(0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/msu_job_driver.md
Name: msu_job_driver

Overview:
- Host-side initiator for the modular-squaring unit's AXI-stream job protocol.
- Accepts one job (t_start, t_final, sq_in) on a valid/ready port, pulses ap_start, then serialises the job LSB-first onto an AXI stream toward the squarer.
- Collects the returned stream (t_current, redundant sq_out), checks framing, and presents the unpacked result on a valid/ready port.
- Sits between the DMA/host shell and the squarer core in the FPGA image.

Parameters:
- AXI_LEN, 32: AXI data width in bits; must be a multiple of 8.
- T_LEN, 64: width of the iteration counters.
- SQ_IN_BITS, 1024: width of the non-redundant input operand.
- SQ_OUT_BITS, 1056: width of the redundant output operand.
- TIMEOUT_CYCLES, 1048576: watchdog limit; used only with MSU_DRV_TIMEOUT_EN.
- Derived, not overridable: IN_COUNT = ceil((2*T_LEN+SQ_IN_BITS)/AXI_LEN), which is 36 at defaults.
- Derived, not overridable: OUT_COUNT = ceil((T_LEN+SQ_OUT_BITS)/AXI_LEN), which is 35 at defaults.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- job_valid  in  1  job offered.
- job_ready  out  1  driver can accept a job.
- job_t_start  in  T_LEN  starting iteration.
- job_t_final  in  T_LEN  final iteration.
- job_sq_in  in  SQ_IN_BITS  input operand.
- ap_start  out  1  one-cycle start pulse to the squarer.
- m_axis_tvalid  out  1  job word valid.
- m_axis_tready  in  1  squarer accepts word.
- m_axis_tdata  out  AXI_LEN  job word.
- m_axis_tkeep  out  AXI_LEN/8  always all ones.
- m_axis_tlast  out  1  last job word.
- s_axis_tvalid  in  1  result word valid.
- s_axis_tready  out  1  driver accepts result word.
- s_axis_tdata  in  AXI_LEN  result word.
- s_axis_tlast  in  1  last result word.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes result.
- res_t_current  out  T_LEN  returned iteration count.
- res_sq_out  out  SQ_OUT_BITS  returned redundant operand.
- res_deadlock  out  1  squarer reported deadlock (t_current all ones).
- res_frame_err  out  1  tlast missing or early.
- res_timeout  out  1  watchdog fired; constant 0 without the macro.
- busy  out  1  any state other than IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0 except job_ready=1. Counters and result registers cleared. Reset mid-job aborts immediately, with no partial result and no tlast.
- IDLE:
  - job_ready=1.
  - On job_valid&&job_ready, latch the packed vector {zero pad, sq_in, t_final, t_start} of IN_COUNT*AXI_LEN bits, with t_start at bits [T_LEN-1:0]. Go to START.
- START: ap_start=1 for exactly one cycle, then go to SEND. There is no tvalid in the START cycle.
- SEND:
  - m_axis_tvalid=1 and tdata = low AXI_LEN bits of the shift register.
  - On tvalid&&tready, shift right by AXI_LEN and increment tx_cnt.
  - tlast=1 when tx_cnt==IN_COUNT-1.
  - tdata and tlast are held stable while tready=0.
  - The last handshake goes to RECV.
- RECV:
  - s_axis_tready=1.
  - Each handshake shifts s_axis_tdata into the MSB of an OUT_COUNT*AXI_LEN register and increments rx_cnt.
  - Completion on tlast or on rx_cnt==OUT_COUNT-1, whichever comes first.
  - res_frame_err=1 if tlast occurs with rx_cnt!=OUT_COUNT-1, or if the word at rx_cnt==OUT_COUNT-1 lacks tlast.
  - On early tlast, the register is additionally shifted so that received words stay LSB-aligned.
  - After completion, go to DELIVER.
- DELIVER:
  - res_valid=1. res_t_current = bits [T_LEN-1:0]; res_sq_out = next SQ_OUT_BITS bits.
  - res_deadlock = &res_t_current.
  - Outputs are held until res_valid&&res_ready; that handshake goes to IDLE.
  - job_ready becomes 1 the cycle after the handshake.
- Latency: the first job word appears 2 cycles after the job handshake.
- Words arriving on s_axis outside RECV are not accepted (tready=0).
- Back-to-back jobs are not pipelined: one job in flight.
- Error flags are valid only with res_valid and clear on entering IDLE.

Optional Feature:
- Macro MSU_DRV_TIMEOUT_EN.
- When defined:
  - A 32-bit watchdog counts cycles in SEND and RECV and clears on every AXI handshake.
  - On reaching TIMEOUT_CYCLES, go straight to DELIVER with res_timeout=1 and whatever result bits have been collected.
  - s_axis_tready and m_axis_tvalid drop the same cycle.
- When undefined: no counter logic, res_timeout tied to 0, and the driver waits indefinitely.

Test Plan:
- Basic job: t_start=0, t_final=5, sq_in=0x3, squarer model always ready. Expect 36 words, word0=0, word1=0, word2=5, word4=0x3, tlast only on word35, ap_start pulsed once. Reply with 35 words whose word0=5 and word2=0x9 -> res_t_current=5, res_sq_out[31:0]=0x9, no error flags.
- Backpressure: toggle m_axis_tready 1-0-0-1 and res_ready low for 10 cycles -> tdata stable while stalled, no duplicated or dropped words, res_valid held 10 cycles.
- Deadlock marker: reply word0=word1=0xFFFFFFFF -> res_deadlock=1.
- Framing: tlast on reply word 20 -> res_frame_err=1, received words LSB-aligned. A separate run with no tlast on word 34 -> res_frame_err=1.
- Reset mid-SEND after 10 words -> next cycle: tvalid=0, job_ready=1, no res_valid. A new job then completes normally.
- With MSU_DRV_TIMEOUT_EN and TIMEOUT_CYCLES=100, squarer never replies -> res_valid and res_timeout=1 exactly 100 cycles after the last job word.
